// File: rtl/ast_pkt_arbiter.sv
// Packet-level round-robin merge of N_SRC Avalon-ST sources into one registered output stage.
// Define ARB_CHANNEL_TAG_EN to replace the output channel with the granted source index.
module ast_pkt_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 10,
  parameter int ERR_CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [N_SRC*DATA_W-1:0]   src_data_i,
  input  logic [N_SRC*EMPTY_W-1:0]  src_empty_i,
  input  logic [N_SRC*CHANNEL_W-1:0] src_channel_i,
  input  logic [N_SRC-1:0]          src_startofpacket_i,
  input  logic [N_SRC-1:0]          src_endofpacket_i,
  input  logic [N_SRC-1:0]          src_valid_i,
  output logic [N_SRC-1:0]          src_ready_o,
  output logic [DATA_W-1:0]         ast_data_o,
  output logic [EMPTY_W-1:0]        ast_empty_o,
  output logic [CHANNEL_W-1:0]      ast_channel_o,
  output logic                      ast_startofpacket_o,
  output logic                      ast_endofpacket_o,
  output logic                      ast_valid_o,
  input  logic                      ast_ready_i,
  output logic [N_SRC-1:0]          grant_o,
  output logic [ERR_CNT_W-1:0]      err_cnt_o
);
  // state  | meaning
  // IDLE   | no grant; arbitrate sop requests, drop stray beats
  // LOCKED | granted source streams beats until its eop is accepted

  localparam int IDX_W = $clog2(N_SRC);
  localparam int CNT_W = IDX_W + 1;
  localparam int SUM_W = ((ERR_CNT_W > CNT_W) ? ERR_CNT_W : CNT_W) + 1;
  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_SRC);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t               r_state, w_state_nxt;
  logic [N_SRC-1:0]     r_grant, w_grant_nxt, w_ready, w_req, w_drop;
  logic [IDX_W-1:0]     r_gidx, w_gidx_nxt, r_rr_ptr, w_rr_nxt, w_sel;
  logic [IDX_W:0]       w_pos;
  logic                 w_found, w_accept, w_slot_rdy;
  logic [CNT_W-1:0]     w_drop_cnt;
  logic [SUM_W-1:0]     w_err_sum;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_nxt;

  logic [DATA_W-1:0]    r_data;
  logic [EMPTY_W-1:0]   r_empty;
  logic [CHANNEL_W-1:0] r_chan, w_chan;
  logic                 r_sop, r_eop, r_valid;

  logic [DATA_W-1:0]    w_src_data [N_SRC];
  logic [EMPTY_W-1:0]   w_src_empty[N_SRC];
  logic [CHANNEL_W-1:0] w_src_chan [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_slice
    assign w_src_data[g]  = src_data_i[g*DATA_W +: DATA_W];
    assign w_src_empty[g] = src_empty_i[g*EMPTY_W +: EMPTY_W];
    assign w_src_chan[g]  = src_channel_i[g*CHANNEL_W +: CHANNEL_W];
  end

  assign w_req      = src_valid_i & src_startofpacket_i;
  assign w_drop     = (r_state == S_IDLE) ? (src_valid_i & ~src_startofpacket_i) : '0;
  assign w_slot_rdy = ~r_valid | ast_ready_i;

  // Circular search starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_pos   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_pos = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      if (w_pos >= N_EXT) w_pos = w_pos - N_EXT;
      if (!w_found && w_req[w_pos[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_pos[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_drop_cnt = '0;
    for (int i = 0; i < N_SRC; i++) w_drop_cnt = w_drop_cnt + CNT_W'(w_drop[i]);
    w_err_sum = SUM_W'(r_err_cnt) + SUM_W'(w_drop_cnt);
    w_err_nxt = (|w_err_sum[SUM_W-1:ERR_CNT_W]) ? '1 : w_err_sum[ERR_CNT_W-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_rr_nxt    = r_rr_ptr;
    w_ready     = '0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = w_drop;
        if (w_found) begin
          w_state_nxt = S_LOCKED;
          w_gidx_nxt  = w_sel;
          w_grant_nxt = '0;
          w_grant_nxt[w_sel] = 1'b1;
        end
      end
      S_LOCKED: begin
        w_ready[r_gidx] = w_slot_rdy;
        w_accept        = src_valid_i[r_gidx] & w_slot_rdy;
        if (w_accept && src_endofpacket_i[r_gidx]) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = (r_gidx == IDX_W'(N_SRC-1)) ? '0 : r_gidx + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_gidx    <= w_gidx_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_err_cnt <= w_err_nxt;
    end
  end

`ifdef ARB_CHANNEL_TAG_EN
  assign w_chan = CHANNEL_W'(r_gidx);
`else
  assign w_chan = w_src_chan[r_gidx];
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_empty <= '0;
      r_chan  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_src_data[r_gidx];
      r_empty <= w_src_empty[r_gidx];
      r_chan  <= w_chan;
      r_sop   <= src_startofpacket_i[r_gidx];
      r_eop   <= src_endofpacket_i[r_gidx];
    end else if (ast_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign src_ready_o         = w_ready;
  assign grant_o             = r_grant;
  assign err_cnt_o           = r_err_cnt;
  assign ast_valid_o         = r_valid;
  assign ast_data_o          = r_data;
  assign ast_empty_o         = r_empty;
  assign ast_channel_o       = r_chan;
  assign ast_startofpacket_o = r_sop;
  assign ast_endofpacket_o   = r_eop;
endmodule

// File: tb/tb_ast_pkt_arbiter.sv
// Scoreboard bench for ast_pkt_arbiter: per-source stimulus queues, expected beats/grants
// queued in hand-computed order, a monitor popping on every output transfer.
module tb_ast_pkt_arbiter;
  localparam int N = 4, DW = 64, EW = 3, CW = 10;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            arst_n_i;
  logic [N*DW-1:0] src_data_i;
  logic [N*EW-1:0] src_empty_i;
  logic [N*CW-1:0] src_channel_i;
  logic [N-1:0]    src_startofpacket_i, src_endofpacket_i, src_valid_i, src_ready_o;
  logic [DW-1:0]   ast_data_o;
  logic [EW-1:0]   ast_empty_o;
  logic [CW-1:0]   ast_channel_o;
  logic            ast_startofpacket_o, ast_endofpacket_o, ast_valid_o, ast_ready_i;
  logic [N-1:0]    grant_o;
  logic [15:0]     err_cnt_o;

  logic [N-1:0]    s_ready, s_grant;
  logic [DW-1:0]   s_data;
  logic [EW-1:0]   s_empty;
  logic [CW-1:0]   s_chan;
  logic            s_sop, s_eop, s_valid;
  logic [1:0]      s_err;

  ast_pkt_arbiter dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .src_data_i(src_data_i), .src_empty_i(src_empty_i), .src_channel_i(src_channel_i),
    .src_startofpacket_i(src_startofpacket_i), .src_endofpacket_i(src_endofpacket_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .ast_data_o(ast_data_o), .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o),
    .ast_startofpacket_o(ast_startofpacket_o), .ast_endofpacket_o(ast_endofpacket_o),
    .ast_valid_o(ast_valid_o), .ast_ready_i(ast_ready_i),
    .grant_o(grant_o), .err_cnt_o(err_cnt_o)
  );

  // Narrow counter copy, used only for the saturation check.
  ast_pkt_arbiter #(.ERR_CNT_W(2)) dut_sat (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .src_data_i(src_data_i), .src_empty_i(src_empty_i), .src_channel_i(src_channel_i),
    .src_startofpacket_i(src_startofpacket_i), .src_endofpacket_i(src_endofpacket_i),
    .src_valid_i(src_valid_i), .src_ready_o(s_ready),
    .ast_data_o(s_data), .ast_empty_o(s_empty), .ast_channel_o(s_chan),
    .ast_startofpacket_o(s_sop), .ast_endofpacket_o(s_eop),
    .ast_valid_o(s_valid), .ast_ready_i(ast_ready_i),
    .grant_o(s_grant), .err_cnt_o(s_err)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  empty;
    logic [9:0]  chan;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t stim [N][64];
  int    head [N];
  int    tail [N];
  beat_t exp_q[$];
  int    exp_g[$];

  int    checks = 0, errors = 0;
  int    cyc = 0;
  bit    rdy_tog = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  bit    fair_phase = 1'b0;
  int    n_xfer = 0, first_x = 0, last_x = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout_or_unexpected required=expected_event", name);
  endtask

  function automatic logic [9:0] exp_chan(input int k, input logic [9:0] c);
`ifdef ARB_CHANNEL_TAG_EN
    return 10'(k);
`else
    return c;
`endif
  endfunction

  task automatic send_pkt(input int k, input int n, input logic [63:0] base, input logic [9:0] ch,
                          input logic [2:0] emp, input bit expect_out, input int mid_sop);
    beat_t bt, e;
    for (int b = 0; b < n; b++) begin
      bt.data  = base + 64'(b);
      bt.empty = (b == n-1) ? emp : 3'd0;
      bt.chan  = ch;
      bt.sop   = (b == 0) || (b == mid_sop);
      bt.eop   = (b == n-1);
      stim[k][tail[k]] = bt;
      tail[k]++;
      if (expect_out) begin
        e = bt;
        e.chan = exp_chan(k, ch);
        exp_q.push_back(e);
      end
    end
    if (expect_out) exp_g.push_back(k);
  endtask

  task automatic send_bad(input int k);
    beat_t bt;
    bt = '{data: 64'hDEAD, empty: 3'd7, chan: 10'h3FF, sop: 1'b0, eop: 1'b0};
    stim[k][tail[k]] = bt;
    tail[k]++;
  endtask

  function automatic bit stim_empty();
    for (int k = 0; k < N; k++) if (head[k] < tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i); #3;
      done = (exp_q.size() == 0) && (exp_g.size() == 0) && (grant_o == '0) && !ast_valid_o && stim_empty();
      if (done) break;
    end
    if (!done) fail_now({name, "_drain"});
  endtask

  // Driver: present queue heads, advance on handshake seen just before the edge.
  initial begin
    logic [N-1:0] hs;
    beat_t bt;
    forever begin
      @(negedge clk_i);
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (head[k] < tail[k]) begin
          bt = stim[k][head[k]];
          src_valid_i[k]              = 1'b1;
          src_data_i[k*DW +: DW]      = bt.data;
          src_empty_i[k*EW +: EW]     = bt.empty;
          src_channel_i[k*CW +: CW]   = bt.chan;
          src_startofpacket_i[k]      = bt.sop;
          src_endofpacket_i[k]        = bt.eop;
        end else begin
          src_valid_i[k]         = 1'b0;
          src_startofpacket_i[k] = 1'b0;
          src_endofpacket_i[k]   = 1'b0;
        end
      end
      ast_ready_i = rdy_tog ? rdy_pat[cyc[1:0]] : 1'b1;
      #1;
      hs = src_valid_i & src_ready_o;
      @(posedge clk_i);
      if (arst_n_i)
        for (int k = 0; k < N; k++) if (hs[k] && head[k] < tail[k]) head[k]++;
    end
  end

  // Monitor: grants on 0->onehot, beats on each valid&ready transfer, hold during stalls.
  initial begin
    beat_t got, prev, e;
    bit stall;
    logic [N-1:0] pg;
    int gi;
    stall = 1'b0;
    pg = '0;
    prev = '0;
    forever begin
      @(negedge clk_i); #2;
      if (!arst_n_i) begin
        stall = 1'b0;
        pg = '0;
        continue;
      end
      if (grant_o != '0 && pg == '0) begin
        if (exp_g.size() == 0) fail_now("unexpected_grant");
        else begin
          gi = exp_g.pop_front();
          chk("grant_order", 128'(grant_o), 128'(4'b0001 << gi));
        end
      end
      got = {ast_data_o, ast_empty_o, ast_channel_o, ast_startofpacket_o, ast_endofpacket_o};
      if (stall) chk("stall_hold", 128'(got), 128'(prev));
      if (ast_valid_o && !ast_ready_i) chk("stall_ready", 128'(src_ready_o), 128'(0));
      if (ast_valid_o && ast_ready_i) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else begin
          e = exp_q.pop_front();
          chk("beat", 128'(got), 128'(e));
        end
        if (fair_phase) begin
          if (n_xfer == 0) first_x = cyc;
          last_x = cyc;
          n_xfer++;
        end
      end
      stall = ast_valid_o && !ast_ready_i;
      prev = got;
      pg = grant_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    arst_n_i = 1'b0;
    src_data_i = '0; src_empty_i = '0; src_channel_i = '0;
    src_startofpacket_i = '0; src_endofpacket_i = '0; src_valid_i = '0;
    ast_ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin head[k] = 0; tail[k] = 0; end

    repeat (3) @(negedge clk_i);
    #3;
    chk("reset_outputs", 128'({ast_valid_o, ast_data_o, ast_empty_o, ast_channel_o, ast_startofpacket_o,
                               ast_endofpacket_o, grant_o, src_ready_o, err_cnt_o}), 128'(0));
    chk("reset_sat_err", 128'(s_err), 128'(0));
    arst_n_i = 1'b1;

    // Fairness: two rounds of 3-beat packets from every source.
    fair_phase = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N; k++)
        send_pkt(k, 3, 64'hA000 + 64'(k*256 + p*16), 10'(k*3+1), 3'(k+1), 1'b1, -1);
    wait_idle("fair");
    fair_phase = 1'b0;
    chk("fair_beats", 128'(n_xfer), 128'(24));
    chk("fair_span", 128'(last_x - first_x), 128'(30));

    // Backpressure: 5-beat packet from source 2 under a 1,0,0,1 ready pattern.
    rdy_tog = 1'b1;
    send_pkt(2, 5, 64'h10, 10'h020, 3'd2, 1'b1, -1);
    wait_idle("backpressure");
    rdy_tog = 1'b0;

    // Malformed beats while idle.
    repeat (3) send_bad(1);
    wait_idle("malformed");
    chk("err_cnt_3", 128'(err_cnt_o), 128'(3));
    chk("sat_err_3", 128'(s_err), 128'(3));

    // Two drops in the same cycle as a single-beat packet request from source 3.
    send_bad(0);
    send_bad(2);
    send_pkt(3, 1, 64'h3333, 10'h033, 3'd5, 1'b1, -1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #3;
      if (src_valid_i[3]) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("single_request");
    chk("drop_ready", 128'(src_ready_o), 128'(4'b0101));
    @(posedge clk_i); #1;
    chk("grant_latency", 128'(grant_o), 128'(4'b1000));
    chk("idle_no_beat", 128'(ast_valid_o), 128'(0));
    chk("err_cnt_5", 128'(err_cnt_o), 128'(5));
    chk("sat_err_hold", 128'(s_err), 128'(3));
    @(posedge clk_i); #1;
    chk("single_idle", 128'(grant_o), 128'(0));
    chk("single_valid", 128'(ast_valid_o), 128'(1));
    chk("single_empty", 128'(ast_empty_o), 128'(5));
    wait_idle("single");

    // Simultaneous requests after source 3: pointer wrapped to 0, then source 2 with channel 0x155.
    send_pkt(0, 3, 64'h500, 10'h0AA, 3'd1, 1'b1, 1);
    send_pkt(2, 2, 64'h600, 10'h155, 3'd4, 1'b1, -1);
    wait_idle("channel");

    // Reset while source 1 is mid-packet.
    send_pkt(1, 4, 64'h700, 10'h011, 3'd0, 1'b1, -1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #3;
      if (ast_valid_o) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("midpkt_first_beat");
    arst_n_i = 1'b0;
    for (int k = 0; k < N; k++) head[k] = tail[k];
    src_valid_i = '0;
    src_startofpacket_i = '0;
    src_endofpacket_i = '0;
    exp_q.delete();
    exp_g.delete();
    #1;
    chk("reset_midpkt", 128'({ast_valid_o, ast_data_o, ast_empty_o, ast_channel_o, ast_startofpacket_o,
                              ast_endofpacket_o, grant_o, src_ready_o, err_cnt_o}), 128'(0));
    repeat (2) @(negedge clk_i);
    #3;
    arst_n_i = 1'b1;
    send_pkt(0, 2, 64'h800, 10'h0F0, 3'd2, 1'b1, -1);
    send_pkt(3, 2, 64'h900, 10'h0F3, 3'd3, 1'b1, -1);
    wait_idle("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
